// File: rtl/semaphore_ctrl.sv
// Traffic-light controller with pedestrian request latch and night-mode flashing yellow.
// Latency: lamps are Moore-decoded from registered state; ped_pending sets one edge after a request.
// Backpressure: none; the block free-runs on a single internal phase counter.
module semaphore_ctrl #(
  parameter int T_RED       = 5,
  parameter int T_GREEN     = 7,
  parameter int T_YELLOW    = 2,
  parameter int T_MIN_GREEN = 3,
  parameter int T_BLINK     = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pedestrian,
  input  logic       night_mode,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RED       = 3'd0,
    S_GREEN     = 3'd1,
    S_YELLOW    = 3'd2,
    S_BLINK_ON  = 3'd3,
    S_BLINK_OFF = 3'd4
  } state_t;

  // Last counter value of each phase.
  localparam logic [CNT_W-1:0] L_RED_END    = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] L_GREEN_END  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YELLOW_END = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_MIN_GREEN  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_BLINK_END  = CNT_W'(T_BLINK - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ped;
  logic             r_walk;
  logic             w_enter_red;

  // Next-state selection; night_mode is only looked at on phase ends, except in GREEN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RED: begin
        if (r_cnt == L_RED_END) w_next = night_mode ? S_BLINK_ON : S_GREEN;
      end
      S_GREEN: begin
        if ((r_cnt == L_GREEN_END) || night_mode || (r_ped && (r_cnt >= L_MIN_GREEN)))
          w_next = S_YELLOW;
      end
      S_YELLOW: begin
        if (r_cnt == L_YELLOW_END) w_next = night_mode ? S_BLINK_ON : S_RED;
      end
      S_BLINK_ON: begin
        if (r_cnt == L_BLINK_END) w_next = night_mode ? S_BLINK_OFF : S_RED;
      end
      S_BLINK_OFF: begin
        if (r_cnt == L_BLINK_END) w_next = night_mode ? S_BLINK_ON : S_RED;
      end
      default: w_next = S_RED;
    endcase
  end

  // An unknown encoding also counts as entering RED, so it recovers with a clean flag load.
  assign w_enter_red = (w_next == S_RED) && (r_state != S_RED);

  // State, phase counter (restarts on every change, advances once per cycle) and request flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RED;
      r_cnt   <= '0;
      r_ped   <= 1'b0;
      r_walk  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      // Entry into RED serves the request (including one arriving that very cycle).
      if (w_enter_red) begin
        r_ped  <= 1'b0;
        r_walk <= r_ped | pedestrian;
      end else begin
        if (pedestrian) r_ped <= 1'b1;
        if (w_next != S_RED) r_walk <= 1'b0;
      end
    end
  end

  // Moore lamp decode; BLINK_OFF leaves every lamp dark.
  always_comb begin
    green  = 1'b0;
    yellow = 1'b0;
    red    = 1'b0;
    case (r_state)
      S_RED:      red    = 1'b1;
      S_GREEN:    green  = 1'b1;
      S_YELLOW:   yellow = 1'b1;
      S_BLINK_ON: yellow = 1'b1;
      default:    ;
    endcase
  end

  assign walk        = red & r_walk;
  assign ped_pending = r_ped;
  assign state       = r_state;

endmodule

// File: tb/tb_semaphore_ctrl.sv
// Directed table of per-cycle inputs and expected outputs, plus an async-reset sequence.
module tb_semaphore_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pedestrian = 1'b0;
  logic       night_mode = 1'b0;
  logic       green, yellow, red, walk, ped_pending;
  logic [2:0] state;

  semaphore_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pedestrian(pedestrian), .night_mode(night_mode),
    .green(green), .yellow(yellow), .red(red), .walk(walk),
    .ped_pending(ped_pending), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ped;
    logic       night;
    logic [2:0] st;
    logic [2:0] lamps;  // {green, yellow, red}
    logic       walk;
    logic       pp;
  } vec_t;

  localparam logic [2:0] L_R = 3'b001, L_Y = 3'b010, L_G = 3'b100, L_N = 3'b000;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input int n, input logic p, input logic nm, input logic [2:0] st,
                     input logic [2:0] lm, input logic w, input logic pp);
    for (int k = 0; k < n; k++) vecs.push_back('{p, nm, st, lm, w, pp});
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d gyr=%b walk=%b pp=%b, want st=%0d gyr=%b walk=%b pp=%b",
               name, act[7:5], act[4:2], act[1], act[0], exp[7:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] outs();
    return {state, green, yellow, red, walk, ped_pending};
  endfunction

  int red_len;
  int budget;

  initial begin
    // A: no inputs -> RED 5, GREEN 7, YELLOW 2, RED 5
    add(5, 0, 0, 3'd0, L_R, 0, 0);
    add(7, 0, 0, 3'd1, L_G, 0, 0);
    add(2, 0, 0, 3'd2, L_Y, 0, 0);
    add(5, 0, 0, 3'd0, L_R, 0, 0);
    // B: pulse at GREEN cnt0 -> GREEN 3, YELLOW 2, RED 5 with walk
    add(1, 1, 0, 3'd1, L_G, 0, 0);
    add(2, 0, 0, 3'd1, L_G, 0, 1);
    add(2, 0, 0, 3'd2, L_Y, 0, 1);
    add(5, 0, 0, 3'd0, L_R, 1, 0);
    // C: pulse at GREEN cnt5 -> GREEN still 7
    add(5, 0, 0, 3'd1, L_G, 0, 0);
    add(1, 1, 0, 3'd1, L_G, 0, 0);
    add(1, 0, 0, 3'd1, L_G, 0, 1);
    add(2, 0, 0, 3'd2, L_Y, 0, 1);
    add(5, 0, 0, 3'd0, L_R, 1, 0);
    // D: request in final YELLOW cycle, then a request during RED
    add(7, 0, 0, 3'd1, L_G, 0, 0);
    add(1, 0, 0, 3'd2, L_Y, 0, 0);
    add(1, 1, 0, 3'd2, L_Y, 0, 0);
    add(2, 0, 0, 3'd0, L_R, 1, 0);
    add(1, 1, 0, 3'd0, L_R, 1, 0);
    add(2, 0, 0, 3'd0, L_R, 1, 1);
    add(3, 0, 0, 3'd1, L_G, 0, 1);
    add(2, 0, 0, 3'd2, L_Y, 0, 1);
    add(5, 0, 0, 3'd0, L_R, 1, 0);
    // E: night at GREEN cnt1, blinking, request during blink, night off in BLINK_OFF
    add(1, 0, 0, 3'd1, L_G, 0, 0);
    add(1, 0, 1, 3'd1, L_G, 0, 0);
    add(2, 0, 1, 3'd2, L_Y, 0, 0);
    add(2, 0, 1, 3'd3, L_Y, 0, 0);
    add(2, 0, 1, 3'd4, L_N, 0, 0);
    add(1, 1, 1, 3'd3, L_Y, 0, 0);
    add(1, 0, 1, 3'd3, L_Y, 0, 1);
    add(1, 0, 1, 3'd4, L_N, 0, 1);
    add(1, 0, 0, 3'd4, L_N, 0, 1);
    // RED with night pulses: mid-phase ignored, at phase end -> BLINK_ON
    add(2, 0, 0, 3'd0, L_R, 1, 0);
    add(1, 0, 1, 3'd0, L_R, 1, 0);
    add(1, 0, 0, 3'd0, L_R, 1, 0);
    add(1, 0, 1, 3'd0, L_R, 1, 0);
    add(2, 0, 0, 3'd3, L_Y, 0, 0);
    add(5, 0, 0, 3'd0, L_R, 0, 0);
    add(1, 0, 0, 3'd1, L_G, 0, 0);

    // Reset state, with a request held during reset that must not latch
    pedestrian = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset_hold", outs(), {3'd0, L_R, 1'b0, 1'b0});
    pedestrian = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].st, vecs[i].lamps, vecs[i].walk, vecs[i].pp});
      pedestrian = vecs[i].ped;
      night_mode = vecs[i].night;
      @(negedge clk);
      #1;
    end
    pedestrian = 1'b0;
    night_mode = 1'b0;

    // Async reset mid-YELLOW with a pending request
    pedestrian = 1'b1;
    @(negedge clk);
    #1 pedestrian = 1'b0;
    budget = 20;
    while (state != 3'd2 && budget > 0) begin
      @(negedge clk);
      #1 budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL wait_yellow: state=%0d after budget, want 2", state);
    end
    check("yellow_pending", outs(), {3'd2, L_Y, 1'b0, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), {3'd0, L_R, 1'b0, 1'b0});
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    #1;
    red_len = 0;
    budget = 20;
    while (state == 3'd0 && red && budget > 0) begin
      red_len++;
      @(negedge clk);
      #1 budget--;
    end
    checks++;
    if (red_len != 5) begin
      errors++;
      $display("FAIL red_after_reset: lasted %0d cycles, want 5", red_len);
    end
    check("green_after_reset", outs(), {3'd1, L_G, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
